// File: rtl/wave_src_sequencer.sv
// Source sequencer for the 6-input waveform mux: auto round-robin scan or manual
// selection, with every source change preceded by a muted gap counted in sample ticks.
module wave_src_sequencer #(
  parameter int DWELL_W = 16,
  parameter int BLANK_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_tick,
  input  logic               auto_en,
  input  logic [2:0]         man_sel,
  input  logic [5:0]         en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank_len,
  output logic [2:0]         sel,
  output logic [2:0]         cur_src,
  output logic               active,
  output logic               switch_pulse,
  output logic               cfg_err
);

  localparam logic [2:0] SEL_MUTE = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_PLAY
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cur_src_q, cur_src_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_lim_q, dwell_lim_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic               mode_q, mode_d;
  logic [2:0]         sel_q, sel_d;
  logic               active_q, active_d;
  logic               switch_q, switch_d;
  logic               cfg_err_q, cfg_err_d;

  // First enabled source at or after 'from', wrapping 5 -> 0.
  function automatic logic [2:0] first_from(input logic [5:0] mask, input logic [2:0] from);
    logic found;
    int   p;
    first_from = from;
    found      = 1'b0;
    for (int k = 0; k < 6; k++) begin
      p = int'(from) + k;
      if (p >= 6) p = p - 6;
      if (!found && mask[p]) begin
        first_from = 3'(p);
        found      = 1'b1;
      end
    end
  endfunction

  logic [7:0]         mask8;
  logic               man_ok;
  logic               cur_en;
  logic [2:0]         next_src;
  logic [DWELL_W-1:0] dwell_lim_new;
  logic               commit, go_idle, restart_dwell;
  logic [2:0]         commit_src;

  // Indices 6 and 7 read as disabled, so an out-of-range man_sel is never valid.
  assign mask8         = {2'b00, en_mask};
  assign man_ok        = mask8[man_sel];
  assign cur_en        = mask8[cur_src_q];
  assign next_src      = first_from(en_mask, (cur_src_q == 3'd5) ? 3'd0 : cur_src_q + 3'd1);
  assign dwell_lim_new = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // NOTE: every always_comb target gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    cur_src_d     = cur_src_q;
    dwell_cnt_d   = dwell_cnt_q;
    dwell_lim_d   = dwell_lim_q;
    blank_cnt_d   = blank_cnt_q;
    mode_d        = mode_q;
    switch_d      = 1'b0;
    cfg_err_d     = 1'b0;
    commit        = 1'b0;
    commit_src    = cur_src_q;
    go_idle       = 1'b0;
    restart_dwell = 1'b0;

    if (stop) begin
      go_idle = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d = auto_en;
            if (auto_en ? (en_mask != 6'd0) : man_ok) begin
              commit     = 1'b1;
              commit_src = auto_en ? first_from(en_mask, 3'd0) : man_sel;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_BLANK, S_PLAY: begin
          if (sample_tick) begin
            mode_d = auto_en;
            if (en_mask == 6'd0) begin
              go_idle = 1'b1;
            end else if (!cur_en) begin
              if (auto_en) begin
                commit     = 1'b1;
                commit_src = next_src;
              end else begin
                go_idle = 1'b1;
              end
            end else if (state_q == S_BLANK) begin
              blank_cnt_d = blank_cnt_q - BLANK_W'(1);
              if (blank_cnt_q == BLANK_W'(1)) state_d = S_PLAY;
            end else if (auto_en != mode_q) begin
              // A mode change only restarts the dwell count on this tick.
              restart_dwell = 1'b1;
            end else if (auto_en) begin
              if (dwell_cnt_q == dwell_lim_q) begin
                if (next_src != cur_src_q) begin
                  commit     = 1'b1;
                  commit_src = next_src;
                end else begin
                  restart_dwell = 1'b1;
                end
              end else begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
              end
            end else if (man_ok && (man_sel != cur_src_q)) begin
              commit     = 1'b1;
              commit_src = man_sel;
            end
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (commit) begin
      cur_src_d     = commit_src;
      switch_d      = 1'b1;
      blank_cnt_d   = blank_len;
      state_d       = (blank_len == '0) ? S_PLAY : S_BLANK;
      restart_dwell = 1'b1;
    end
    if (restart_dwell) begin
      dwell_cnt_d = '0;
      dwell_lim_d = dwell_lim_new;
    end
    if (go_idle) begin
      state_d     = S_IDLE;
      dwell_cnt_d = '0;
      blank_cnt_d = '0;
    end

    sel_d    = (state_d == S_PLAY) ? cur_src_d : SEL_MUTE;
    active_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_src_q   <= 3'd0;
      dwell_cnt_q <= '0;
      dwell_lim_q <= '0;
      blank_cnt_q <= '0;
      mode_q      <= 1'b0;
      sel_q       <= SEL_MUTE;
      active_q    <= 1'b0;
      switch_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_lim_q <= dwell_lim_d;
      blank_cnt_q <= blank_cnt_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      active_q    <= active_d;
      switch_q    <= switch_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign sel          = sel_q;
  assign cur_src      = cur_src_q;
  assign active       = active_q;
  assign switch_pulse = switch_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_wave_src_sequencer.sv
// Bench for wave_src_sequencer: a tick-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_wave_src_sequencer;

  localparam int DWELL_W = 16;
  localparam int BLANK_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, stop, sample_tick, auto_en;
  logic [2:0]         man_sel;
  logic [5:0]         en_mask;
  logic [DWELL_W-1:0] dwell;
  logic [BLANK_W-1:0] blank_len;
  logic [2:0]         sel, cur_src;
  logic               active, switch_pulse, cfg_err;

  wave_src_sequencer #(.DWELL_W(DWELL_W), .BLANK_W(BLANK_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_tick(sample_tick),
    .auto_en(auto_en), .man_sel(man_sel), .en_mask(en_mask), .dwell(dwell),
    .blank_len(blank_len), .sel(sel), .cur_src(cur_src), .active(active),
    .switch_pulse(switch_pulse), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Behavioural model: a source is "on", possibly muted for m_muted more ticks,
  // and has played m_played ticks out of m_hold.
  bit m_on, m_mode, m_pulse, m_err;
  int m_src, m_muted, m_played, m_hold;

  function automatic int lowest_enabled(input logic [5:0] mask);
    for (int c = 0; c < 6; c++) if (mask[c]) return c;
    return -1;
  endfunction

  function automatic int following_enabled(input int s, input logic [5:0] mask);
    for (int k = 1; k <= 6; k++) if (mask[(s + k) % 6]) return (s + k) % 6;
    return s;
  endfunction

  function automatic int dwell_ticks();
    return (dwell == 0) ? 1 : int'(dwell);
  endfunction

  task automatic model_begin(input int s);
    m_src    = s;
    m_on     = 1'b1;
    m_pulse  = 1'b1;
    m_muted  = int'(blank_len);
    m_played = 0;
    m_hold   = dwell_ticks();
  endtask

  task automatic model_off();
    m_on     = 1'b0;
    m_muted  = 0;
    m_played = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit changed;
    if (rst) begin
      m_on = 0; m_mode = 0; m_pulse = 0; m_err = 0;
      m_src = 0; m_muted = 0; m_played = 0; m_hold = 1;
    end else begin
      m_pulse = 0;
      m_err   = 0;
      if (stop) begin
        model_off();
      end else if (!m_on) begin
        if (start) begin
          m_mode = auto_en;
          if (auto_en && en_mask != 0) model_begin(lowest_enabled(en_mask));
          else if (!auto_en && man_sel < 6 && en_mask[man_sel]) model_begin(int'(man_sel));
          else m_err = 1;
        end
      end else if (sample_tick) begin
        changed = (auto_en != m_mode);
        m_mode  = auto_en;
        if (en_mask == 0) model_off();
        else if (!en_mask[m_src]) begin
          if (auto_en) model_begin(following_enabled(m_src, en_mask));
          else model_off();
        end else if (m_muted > 0) m_muted--;
        else if (changed) begin
          m_played = 0;
          m_hold   = dwell_ticks();
        end else if (auto_en) begin
          m_played++;
          if (m_played == m_hold) begin
            if (following_enabled(m_src, en_mask) != m_src) model_begin(following_enabled(m_src, en_mask));
            else begin
              m_played = 0;
              m_hold   = dwell_ticks();
            end
          end
        end else if (man_sel < 6 && en_mask[man_sel] && int'(man_sel) != m_src) begin
          model_begin(int'(man_sel));
        end
      end
    end
  end

  function automatic int model_sel();
    return (m_on && m_muted == 0) ? m_src : 6;
  endfunction

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    check("sel", int'(sel), model_sel());
    check("active", int'(active), int'(m_on));
    check("cur_src", int'(cur_src), m_src);
    check("switch_pulse", int'(switch_pulse), int'(m_pulse));
    check("cfg_err", int'(cfg_err), int'(m_err));
  end

  // Inputs change 1 time unit after a rising edge; outputs of that edge are then visible.
  task automatic step(input logic tk);
    sample_tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    start = 0; stop = 1; step(0); stop = 0;
  endtask

  int exp_scan [22] = '{6,6,0,0,0,6,6,2,2,2,6,6,3,3,3,6,6,5,5,5,6,6};
  int exp_srcs [5]  = '{0,2,3,5,0};
  int got_srcs [5];
  int n_pulses;

  initial begin
    rst = 1; start = 0; stop = 0; sample_tick = 0; auto_en = 0;
    man_sel = 0; en_mask = 0; dwell = 0; blank_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", int'(sel), 6);
    check("rst_active", int'(active), 0);
    check("rst_cur_src", int'(cur_src), 0);
    rst = 0;

    // Idle with no start for 100 ticks.
    repeat (100) begin step(0); step(1); end
    check("idle_sel", int'(sel), 6);
    check("idle_active", int'(active), 0);

    // Auto scan over mask 101101, dwell 3, mute 2.
    auto_en = 1; en_mask = 6'b101101; dwell = 3; blank_len = 2;
    start = 1; step(0); start = 0;
    check("scan_start_pulse", int'(switch_pulse), 1);
    got_srcs[0] = int'(cur_src);
    n_pulses = 0;
    for (int i = 0; i < 22; i++) begin
      step(0); step(0);
      check("scan_sel", int'(sel), exp_scan[i]);
      check("scan_model_sel", model_sel(), exp_scan[i]);
      step(1);
      if (switch_pulse) begin
        n_pulses++;
        if (n_pulses < 5) got_srcs[n_pulses] = int'(cur_src);
      end
    end
    check("scan_pulses", n_pulses, 4);
    for (int i = 0; i < 5; i++) check("scan_src_seq", got_srcs[i], exp_srcs[i]);
    go_idle();

    // Single source, dwell 0, no mute.
    en_mask = 6'b000100; dwell = 0; blank_len = 0;
    start = 1; step(0); start = 0;
    check("single_start_pulse", int'(switch_pulse), 1);
    check("single_start_sel", int'(sel), 2);
    repeat (20) begin
      step(1);
      check("single_sel", int'(sel), 2);
      check("single_no_pulse", int'(switch_pulse), 0);
    end
    go_idle();

    // Manual mode with a one-tick mute.
    auto_en = 0; en_mask = 6'b111111; blank_len = 1; man_sel = 1;
    start = 1; step(0); start = 0;
    step(1);
    check("man_sel1", int'(sel), 1);
    man_sel = 4;
    step(0);
    check("man_hold1", int'(sel), 1);
    step(1);
    check("man_mute", int'(sel), 6);
    check("man_pulse", int'(switch_pulse), 1);
    check("man_cur4", int'(cur_src), 4);
    step(0); step(1);
    check("man_sel4", int'(sel), 4);
    man_sel = 7;
    repeat (3) begin
      step(0); step(1);
      check("man_bad_sel", int'(sel), 4);
      check("man_bad_no_pulse", int'(switch_pulse), 0);
    end
    go_idle();

    // Invalid start.
    auto_en = 1; en_mask = 6'b000000;
    start = 1; step(0);
    check("err_pulse", int'(cfg_err), 1);
    check("err_idle", int'(active), 0);
    start = 0; step(0);
    check("err_once", int'(cfg_err), 0);

    // Remove the playing source, then the whole mask.
    en_mask = 6'b111111; dwell = 10; blank_len = 0;
    start = 1; step(0); start = 0;
    repeat (3) step(1);
    en_mask = 6'b111110;
    step(0);
    check("rm_wait", int'(sel), 0);
    step(1);
    check("rm_pulse", int'(switch_pulse), 1);
    check("rm_sel", int'(sel), 1);
    en_mask = 6'b000000;
    step(1);
    check("rm_all_idle", int'(active), 0);
    check("rm_all_sel", int'(sel), 6);
    check("rm_all_no_pulse", int'(switch_pulse), 0);

    // stop beats start and a due switch on the same tick.
    en_mask = 6'b000011; dwell = 2; blank_len = 0;
    start = 1; step(0); start = 0;
    step(1);
    stop = 1; start = 1; step(1);
    check("stop_idle", int'(active), 0);
    check("stop_sel", int'(sel), 6);
    check("stop_no_pulse", int'(switch_pulse), 0);
    stop = 0; start = 0; step(0);

    // Reset in the middle of a mute gap.
    en_mask = 6'b111000; blank_len = 5;
    start = 1; step(0); start = 0;
    step(1);
    check("pre_rst_active", int'(active), 1);
    check("pre_rst_cur", int'(cur_src), 3);
    rst = 1; #1;
    check("mid_rst_sel", int'(sel), 6);
    check("mid_rst_active", int'(active), 0);
    check("mid_rst_cur", int'(cur_src), 0);
    check("mid_rst_pulse", int'(switch_pulse), 0);
    step(0);
    rst = 0;
    step(1); step(0);
    check("post_rst_idle", int'(active), 0);

    // Randomized soak against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 7) == 0) man_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) en_mask = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) dwell = DWELL_W'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) blank_len = BLANK_W'($urandom_range(0, 3));
      step($urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
